// File: rtl/circ_pkg.sv
// Shared constants, state type and per-word delay helper for the
// CIRC C1->C2 deinterleave sequencer.
package circ_pkg;

  localparam int WORDS     = 28;
  localparam int STAGGER   = 4;
  localparam int MAX_DELAY = (WORDS - 1) * STAGGER;
  localparam int FILL_W    = $clog2(MAX_DELAY + 1);

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Frames of delay applied to word i by the stagger line.
  function automatic logic [FILL_W-1:0] word_delay(input int i);
    int d;
    d = (WORDS - 1 - i) * STAGGER;
    return d[FILL_W-1:0];
  endfunction

endpackage

// File: rtl/circ_erase_mask.sv
// Fill level -> per-word erasure mask (pure combinational).
// Ports: fill (frames of history held), erase (bit i=1: word i lacks history).
module circ_erase_mask
  import circ_pkg::*;
(
  input  logic [FILL_W-1:0] fill,
  output logic [WORDS-1:0]  erase
);

  always_comb begin
    erase = '0;
    for (int i = 0; i < WORDS; i++) begin
      erase[i] = (fill < word_delay(i));
    end
  end

endmodule

// File: rtl/circ_deint_ctrl.sv
// Sequencer for the CIRC stagger deinterleaver: accepts C1 frames,
// pulses shift_en per accept, presents frame number + erasure mask to C2.
// Ports: CLK, RST (sync, active-high), sync_lost, in_valid/in_ready,
//        shift_en, out_valid/out_ready, out_erase, out_fnum, primed.
module circ_deint_ctrl
  import circ_pkg::*;
#(
  parameter int FNUM_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sync_lost,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shift_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORDS-1:0]  out_erase,
  output logic [FNUM_W-1:0] out_fnum,
  output logic              primed
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_DELAY);

  state_t            state;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_inc;
  logic [WORDS-1:0]  mask;
  logic              accept;

  // Single output slot: take a new frame only if the slot is empty
  // or being drained this cycle. sync_lost blocks the accept so no
  // shift can coincide with a history flush.
  assign in_ready = !RST && !sync_lost && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign shift_en = accept;

  assign fill_inc = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);

  // Mask is computed from the fill level before this frame counts.
  circ_erase_mask u_mask (
    .fill  (fill),
    .erase (mask)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= PRIME;
      fill      <= '0;
      out_valid <= 1'b0;
      out_erase <= '1;
      out_fnum  <= '0;
      primed    <= 1'b0;
    end else if (sync_lost) begin
      // History discarded; the frame number keeps counting.
      state     <= PRIME;
      fill      <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else if (accept) begin
      fill      <= fill_inc;
      out_valid <= 1'b1;
      out_erase <= mask;
      out_fnum  <= out_fnum + FNUM_W'(1);
      if (fill_inc == FILL_MAX) begin
        state  <= RUN;
        primed <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  logic unused_state;
  assign unused_state = (state == RUN);

endmodule

// File: tb/tb_circ_deint_ctrl.sv
// Self-checking bench for circ_deint_ctrl: directed sequences with a
// scoreboard of expected {erase, fnum} popped by a consumer monitor.
module tb_circ_deint_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        sync_lost = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        shift_en;
  logic        out_valid;
  logic [27:0] out_erase;
  logic [15:0] out_fnum;
  logic        primed;

  circ_deint_ctrl #(.FNUM_W(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .sync_lost (sync_lost),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_erase (out_erase),
    .out_fnum  (out_fnum),
    .primed    (primed)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [27:0] erase;
    logic [15:0] fnum;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  int m_fill = 0;
  logic [15:0] m_fnum = '0;
  logic m_ov = 1'b0;
  logic m_primed = 1'b0;
  logic m_ready, m_acc;

  int n_shift = 0;
  int n_acc = 0;
  int n_cons = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] exp_mask(input int f);
    logic [27:0] e;
    for (int i = 0; i < 28; i++) e[i] = (f < (27 - i) * 4);
    return e;
  endfunction

  // One clock: drive at negedge, check pre-edge outputs, advance model.
  task automatic cyc(input logic rst, input logic sl,
                     input logic iv, input logic ordy);
    @(negedge CLK);
    RST = rst;
    sync_lost = sl;
    in_valid = iv;
    out_ready = ordy;
    #2;
    m_ready = !rst && !sl && (!m_ov || ordy);
    m_acc = iv && m_ready;
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("shift_en", 32'(shift_en), 32'(m_acc));
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("primed", 32'(primed), 32'(m_primed));
    end
    if (shift_en) n_shift++;
    if (rst) begin
      m_fill = 0;
      m_fnum = '0;
      m_ov = 1'b0;
      m_primed = 1'b0;
      sb.delete();
    end else if (sl) begin
      if (m_ov && !ordy && sb.size() > 0) void'(sb.pop_back());
      m_fill = 0;
      m_ov = 1'b0;
      m_primed = 1'b0;
    end else if (m_acc) begin
      n_acc++;
      sb.push_back({exp_mask(m_fill), m_fnum + 16'd1});
      m_fnum = m_fnum + 16'd1;
      if (m_fill < 108) m_fill++;
      if (m_fill == 108) m_primed = 1'b1;
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  // Consumer monitor: a frame is taken when valid && ready before the edge.
  always @(negedge CLK) begin
    exp_t e;
    #3;
    if (!RST && out_valid && out_ready) begin
      n_cons++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(out_fnum), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out_erase", 32'(out_erase), 32'(e.erase));
        chk("out_fnum", 32'(out_fnum), 32'(e.fnum));
      end
    end
  end

  initial begin
    int guard;
    void'($urandom(32'd1234));

    // Reset and reset-state values.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_erase", 32'(out_erase), 32'h0FFF_FFFF);
    chk("rst_fnum", 32'(out_fnum), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);

    // 1: full-throughput priming.
    for (int k = 0; k < 120; k++) begin
      cyc(0, 0, 1, 1);
      if (k == 1) chk("t1_first_erase", 32'(out_erase), 32'h07FF_FFFF);
      if (k == 5) chk("t1_frame4_erase", 32'(out_erase), 32'h03FF_FFFF);
      if (k == 107) chk("t1_primed_107", 32'(primed), 32'd0);
      if (k == 108) begin
        chk("t1_frame107_erase", 32'(out_erase), 32'h1);
        chk("t1_primed_108", 32'(primed), 32'd1);
      end
      if (k == 109) chk("t1_frame108_erase", 32'(out_erase), 32'h0);
    end

    // 2: back-pressure.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 0);
      chk("t2_stall_ready", 32'(in_ready), 32'd0);
      chk("t2_hold_fnum", 32'(out_fnum), 32'(m_fnum));
      chk("t2_hold_erase", 32'(out_erase), 32'h0);
    end
    cyc(0, 0, 1, 1);
    chk("t2_resume_shift", 32'(shift_en), 32'd1);

    // 3: sync loss in RUN with a pending frame.
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    chk("t3_no_shift", 32'(shift_en), 32'd0);
    cyc(0, 0, 0, 1);
    chk("t3_valid_drop", 32'(out_valid), 32'd0);
    chk("t3_primed_drop", 32'(primed), 32'd0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    chk("t3_erase_restart", 32'(out_erase), 32'h07FF_FFFF);
    chk("t3_fnum_cont", 32'(out_fnum), 32'(m_fnum));

    // 4: frame number wrap.
    guard = 0;
    while (m_fnum != 16'hFFFF && guard < 70000) begin
      cyc(0, 0, 1, 1);
      guard++;
    end
    chk("t4_guard", 32'(m_fnum), 32'hFFFF);
    cyc(0, 0, 1, 1);
    chk("t4_fnum_ffff", 32'(out_fnum), 32'hFFFF);
    cyc(0, 0, 0, 1);
    chk("t4_fnum_wrap", 32'(out_fnum), 32'h0);

    // 5: reset mid-run with a pending frame.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    chk("t5_shift_rst", 32'(shift_en), 32'd0);
    cyc(0, 0, 0, 0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_erase", 32'(out_erase), 32'h0FFF_FFFF);
    chk("t5_fnum", 32'(out_fnum), 32'd0);
    chk("t5_primed", 32'(primed), 32'd0);

    // 6: random handshakes.
    n_shift = 0;
    n_acc = 0;
    n_cons = 0;
    for (int k = 0; k < 300; k++) begin
      cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 0, 0);
    chk("t6_shift_vs_acc", 32'(n_shift), 32'(n_acc));
    chk("t6_acc_vs_out", 32'(n_acc), 32'(n_cons + int'(m_ov)));
    chk("t6_some_acc", 32'(n_acc > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
